// File: rtl/v_lane_sync_fifo.sv
// Single-clock vector-lane FIFO with flush, occupancy and almost-full/empty flags.
// Define V_LANE_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module v_lane_sync_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 512,
  parameter int AFULL_OFFSET  = 4,
  parameter int AEMPTY_OFFSET = 4,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almostempty_o,
  output logic                  almostfull_o,
  output logic [CW-1:0]         level_o,
  output logic [CW-1:0]         rdcount_o,
  output logic [CW-1:0]         wrcount_o,
  output logic                  rderr_o,
  output logic                  wrerr_o
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH  = CW'(DEPTH - AFULL_OFFSET);
  localparam logic [CW-1:0] AEMPTY_TH = CW'(AEMPTY_OFFSET);
  localparam logic [CW-1:0] PTR_ONE   = CW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         level;
  logic                  empty, full;
  logic                  rd_acc, wr_acc;
  logic                  rderr_d, rderr_q;
  logic                  wrerr_d, wrerr_q;

  // The wrap bit makes full (difference == DEPTH) distinguishable from empty.
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == DEPTH_C);

  // NOTE: always_comb uses blocking assignments, and every output gets a default
  // before any branch so no latch can be inferred.
  always_comb begin
    rd_acc   = re_i && !empty && !clear_i;
    wr_acc   = we_i && (!full || rd_acc) && !clear_i;
    rderr_d  = re_i && empty && !clear_i;
    wrerr_d  = we_i && !wr_acc && !clear_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rderr_q  <= 1'b0;
      wrerr_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rderr_q  <= rderr_d;
      wrerr_q  <= wrerr_d;
    end
  end

  // NOTE: the storage array has no reset; only the pointers define what is valid,
  // which lets the array map onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

`ifdef V_LANE_FIFO_FWFT_EN
  // Head word is presented directly; forced to zero while empty for a clean reset value.
  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  // When full with a simultaneous write, both ports hit one address; the read sees the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign rdata_o = rdata_q;
`endif

  assign empty_o       = empty;
  assign full_o        = full;
  assign almostempty_o = (level <= AEMPTY_TH);
  assign almostfull_o  = (level >= AFULL_TH);
  assign level_o       = level;
  assign rdcount_o     = rd_ptr_q;
  assign wrcount_o     = wr_ptr_q;
  assign rderr_o       = rderr_q;
  assign wrerr_o       = wrerr_q;

endmodule

// File: tb/tb_v_lane_sync_fifo.sv
// Scoreboard bench for v_lane_sync_fifo (DEPTH=8, offsets 2); follows V_LANE_FIFO_FWFT_EN.
module tb_v_lane_sync_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_i = 1'b0;
  logic          we_i = 1'b0;
  logic [DW-1:0] wdata_i = '0;
  logic          re_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic          empty_o, full_o, almostempty_o, almostfull_o;
  logic [CW-1:0] level_o, rdcount_o, wrcount_o;
  logic          rderr_o, wrerr_o;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mdl [$];
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] m_rd = '0;
  logic [CW-1:0] m_wr = '0;
  logic [DW-1:0] last_pop = '0;
  logic [DW-1:0] fwft_head = '0;
  logic          fwft_valid = 1'b0;
  logic          pop_seen = 1'b0;

  v_lane_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_OFFSET(2), .AEMPTY_OFFSET(2)
  ) dut (
    .clk(clk), .reset(reset), .clear_i(clear_i), .we_i(we_i), .wdata_i(wdata_i),
    .re_i(re_i), .rdata_o(rdata_o), .empty_o(empty_o), .full_o(full_o),
    .almostempty_o(almostempty_o), .almostfull_o(almostfull_o), .level_o(level_o),
    .rdcount_o(rdcount_o), .wrcount_o(wrcount_o), .rderr_o(rderr_o), .wrerr_o(wrerr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input logic exp_rderr, input logic exp_wrerr);
    int lvl;
    lvl = mdl.size();
    check("level_o", DW'(level_o), DW'(lvl));
    check("empty_o", DW'(empty_o), DW'(lvl == 0));
    check("full_o", DW'(full_o), DW'(lvl == DEPTH));
    check("almostempty_o", DW'(almostempty_o), DW'(lvl <= AE_LEVEL));
    check("almostfull_o", DW'(almostfull_o), DW'(lvl >= AF_LEVEL));
    check("rdcount_o", DW'(rdcount_o), DW'(m_rd));
    check("wrcount_o", DW'(wrcount_o), DW'(m_wr));
    check("rderr_o", DW'(rderr_o), DW'(exp_rderr));
    check("wrerr_o", DW'(wrerr_o), DW'(exp_wrerr));
  endtask

  // Applies one cycle of stimulus, advances the reference model, then checks status after the edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
    logic rd_acc, wr_acc, e_rderr, e_wrerr;
    fwft_valid = (mdl.size() != 0);
    if (fwft_valid) fwft_head = mdl[0];
    we_i = we; wdata_i = wd; re_i = re; clear_i = clr;
    rd_acc  = re && (mdl.size() != 0) && !clr;
    wr_acc  = we && ((mdl.size() < DEPTH) || rd_acc) && !clr;
    e_rderr = re && (mdl.size() == 0) && !clr;
    e_wrerr = we && !wr_acc && !clr;
    if (rd_acc) begin
      last_pop = mdl.pop_front();
      exp_q.push_back(last_pop);
      m_rd = m_rd + 4'd1;
    end
    if (wr_acc) begin
      mdl.push_back(wd);
      m_wr = m_wr + 4'd1;
    end
    if (clr) begin
      mdl.delete();
      m_rd = '0;
      m_wr = '0;
    end
    @(posedge clk);
    #1;
    we_i = 1'b0; re_i = 1'b0; clear_i = 1'b0;
    check_status(e_rderr, e_wrerr);
  endtask

  // Monitor: compares read data whenever the DUT completes a pop.
`ifdef V_LANE_FIFO_FWFT_EN
  always @(negedge clk) begin
    if (!reset && fwft_valid) check("fwft_head", rdata_o, fwft_head);
    if (!reset && re_i && !empty_o && !clear_i) begin
      if (exp_q.size() == 0) check("unexpected_pop", rdata_o, 'x);
      else check("rdata_o", rdata_o, exp_q.pop_front());
    end
  end
`else
  always @(posedge clk) pop_seen <= !reset && re_i && !empty_o && !clear_i;

  always @(negedge clk) begin
    if (!reset && pop_seen) begin
      if (exp_q.size() == 0) check("unexpected_pop", rdata_o, 'x);
      else check("rdata_o", rdata_o, exp_q.pop_front());
    end
  end
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while reset is held.
    #3;
    check("rst_level", DW'(level_o), 32'd0);
    check("rst_empty", DW'(empty_o), 32'd1);
    check("rst_aempty", DW'(almostempty_o), 32'd1);
    check("rst_full", DW'(full_o), 32'd0);
    check("rst_afull", DW'(almostfull_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Read on empty: error pulse one cycle, pointers and data stay zero.
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("empty_read_rdata", rdata_o, 32'd0);

    // Simultaneous read/write on empty: read rejected, word lands.
    step(1'b1, 32'h55, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill 0x10..0x17, overflow write, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h10 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hEE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous read/write when full: level holds, no write error.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h20 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hAA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Wrap-around from zeroed pointers: 20 write/read pairs.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hC000 + DW'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      if (i == 7) check("wrap_msb_toggled", DW'(rdcount_o[CW-1]), 32'd1);
    end
    check("wrap_rdcount", DW'(rdcount_o), 32'd4);
    check("wrap_wrcount", DW'(wrcount_o), 32'd4);

    // Flush at level 5 with write and read also requested.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h30 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b1, 1'b1);
`ifndef V_LANE_FIFO_FWFT_EN
    check("flush_rdata_hold", rdata_o, last_pop);
`endif
    step(1'b1, 32'h41, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges at level 3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + DW'(i), 1'b0, 1'b0);
    #5;
    reset = 1'b1;
    #1;
    check("arst_level", DW'(level_o), 32'd0);
    check("arst_empty", DW'(empty_o), 32'd1);
    check("arst_aempty", DW'(almostempty_o), 32'd1);
    check("arst_rdcount", DW'(rdcount_o), 32'd0);
    check("arst_wrcount", DW'(wrcount_o), 32'd0);
    check("arst_rdata", rdata_o, 32'd0);
    reset = 1'b0;
    mdl.delete();
    exp_q.delete();
    m_rd = '0;
    m_wr = '0;
    fwft_valid = 1'b0;

    // Post-reset sanity with back-to-back traffic.
    step(1'b1, 32'h61, 1'b0, 1'b0);
    step(1'b1, 32'h62, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", DW'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
